message_tx_sequencer: RTL and testbench

//  Controller for the message BRAM. On start, reads addresses 1..maxaddr in order and

---
 rtl/message_tx_sequencer_pkg.sv | 36 +++
 rtl/message_tx_sequencer_ack_timer.sv | 54 +++++
 rtl/message_tx_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_message_tx_sequencer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/message_tx_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// message_tx_sequencer_pkg
//   Shared definitions for the message transmit sequencer: FSM state encoding,
//   default protocol parameters (also used by the RX ack decoder) and a helper
//   that sizes counters from their largest value.
// -----------------------------------------------------------------------------
package message_tx_sequencer_pkg;

   // Sequencer states. The encoding is shared with the receive-side tooling.
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_LOAD    = 3'd2,
      ST_SEND    = 3'd3,
      ST_ACKWAIT = 3'd4,
      ST_FAIL    = 3'd5
   } tx_state_e;

   // Protocol defaults; the ack sequence compare uses DEF_SEQW bits.
   localparam int unsigned DEF_SEQW      = 8;
   localparam int unsigned DEF_TIMEOUT   = 1000;
   localparam int unsigned DEF_MAX_RETRY = 3;

   // Smallest width (at least 1) able to hold max_val.
   function automatic int unsigned width_for(input int unsigned max_val);
      int unsigned w;
      w = 32'd1;
      for (int unsigned i = 32'd1; i < 32'd32; i++) begin
         if ((max_val >> i) != 32'd0) begin
            w = i + 32'd1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/message_tx_sequencer_ack_timer.sv
// -----------------------------------------------------------------------------
// message_tx_sequencer_ack_timer
//   Per-attempt acknowledge timer. Counts enabled cycles from 0 and parks at
//   TIMEOUT-1, where expired_o is raised. clear_i restarts the count at 0 and
//   has priority over enable_i.
// Ports:
//   clk        system clock
//   reset      synchronous active-high reset (count returns to 0)
//   clear_i    restart count at 0
//   enable_i   advance the count by one this cycle
//   expired_o  count has reached TIMEOUT-1
// -----------------------------------------------------------------------------
module message_tx_sequencer_ack_timer
   import message_tx_sequencer_pkg::*;
#(
   parameter int unsigned TIMEOUT = DEF_TIMEOUT,
   parameter int unsigned TW      = width_for(TIMEOUT - 32'd1)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam logic [TW-1:0] LAST_COUNT = TW'(TIMEOUT - 32'd1);

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;

   // Next count: clear wins, then advance while below the terminal value.
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LAST_COUNT)) begin
         count_d = count_q + {{(TW-1){1'b0}}, 1'b1};
      end else begin
         count_d = count_q;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign expired_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/message_tx_sequencer.sv
// -----------------------------------------------------------------------------
// message_tx_sequencer
//   Walks the message BRAM from address 1 to the latched maxaddr, offering each
//   word to the laser TX framer as a numbered packet. Each packet waits for an
//   ack carrying its sequence number; on timeout the held packet is resent
//   (no BRAM refetch) until MAX_RETRY resends have been used, then the block
//   parks in FAIL until the next start.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start, abort          run request (IDLE/FAIL only), immediate return to IDLE
//   maxaddr               last BRAM address of the message, latched on start
//   readaddr / dout       BRAM read port (1-cycle registered read)
//   pkt_data/seq/valid    packet offered to the framer, held until pkt_ready
//   pkt_ready             framer accept
//   ack_valid / ack_seq   ack strobe and the sequence number it acknowledges
//   busy, done, fail      status: running, 1-cycle completion, retries exhausted
// -----------------------------------------------------------------------------
module message_tx_sequencer
   import message_tx_sequencer_pkg::*;
#(
   parameter int unsigned LOGSIZE   = 10,
   parameter int unsigned WIDTH     = 64,
   parameter int unsigned SEQW      = DEF_SEQW,
   parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
   parameter int unsigned MAX_RETRY = DEF_MAX_RETRY
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
   input  logic [LOGSIZE-1:0] maxaddr,
   output logic [LOGSIZE-1:0] readaddr,
   input  logic [WIDTH-1:0]   dout,
   output logic [WIDTH-1:0]   pkt_data,
   output logic [SEQW-1:0]    pkt_seq,
   output logic               pkt_valid,
   input  logic               pkt_ready,
   input  logic               ack_valid,
   input  logic [SEQW-1:0]    ack_seq,
   output logic               busy,
   output logic               done,
   output logic               fail
);

   localparam int unsigned          TW          = width_for(TIMEOUT - 32'd1);
   localparam int unsigned          RW          = width_for(MAX_RETRY);
   localparam logic [RW-1:0]        RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [LOGSIZE-1:0]   FIRST_ADDR  = LOGSIZE'(1);
   localparam logic [LOGSIZE-1:0]   ADDR_ONE    = LOGSIZE'(1);
   localparam logic [SEQW-1:0]      SEQ_ONE     = SEQW'(1);
   localparam logic [RW-1:0]        RETRY_ONE   = RW'(1);

   tx_state_e          state_q,    state_d;
   logic [LOGSIZE-1:0] readaddr_q, readaddr_d;
   logic [LOGSIZE-1:0] maxaddr_q,  maxaddr_d;
   logic [WIDTH-1:0]   pkt_data_q, pkt_data_d;
   logic [SEQW-1:0]    pkt_seq_q,  pkt_seq_d;
   logic               pkt_valid_q, pkt_valid_d;
   logic [RW-1:0]      retry_q,    retry_d;
   logic               busy_q,     busy_d;
   logic               done_q,     done_d;
   logic               fail_q,     fail_d;

   logic               timer_clear_s;
   logic               timer_enable_s;
   logic               timer_expired_s;
   logic               ack_match_s;
   logic               last_packet_s;

   // Ack for the packet currently outstanding; only acted on in ACKWAIT.
   assign ack_match_s   = ack_valid && (ack_seq == pkt_seq_q);
   assign last_packet_s = (readaddr_q == maxaddr_q);

   message_tx_sequencer_ack_timer #(
      .TIMEOUT (TIMEOUT),
      .TW      (TW)
   ) u_ack_timer (
      .clk       (clk),
      .reset     (reset),
      .clear_i   (timer_clear_s),
      .enable_i  (timer_enable_s),
      .expired_o (timer_expired_s)
   );

   // Next-state and datapath decode; abort overrides every state and start.
   always_comb begin
      state_d        = state_q;
      readaddr_d     = readaddr_q;
      maxaddr_d      = maxaddr_q;
      pkt_data_d     = pkt_data_q;
      pkt_seq_d      = pkt_seq_q;
      pkt_valid_d    = pkt_valid_q;
      retry_d        = retry_q;
      done_d         = 1'b0;
      timer_clear_s  = 1'b0;
      timer_enable_s = 1'b0;

      if (abort) begin
         state_d     = ST_IDLE;
         pkt_valid_d = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_FAIL: begin
               if (start) begin
                  maxaddr_d = maxaddr;
                  if (maxaddr == '0) begin
                     // Empty message: report completion without touching the BRAM.
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     readaddr_d = FIRST_ADDR;
                     pkt_seq_d  = '0;
                     retry_d    = '0;
                     state_d    = ST_FETCH;
                  end
               end else begin
                  state_d = state_q;
               end
            end

            ST_FETCH: begin
               // BRAM samples readaddr on this edge; data is usable in LOAD.
               state_d = ST_LOAD;
            end

            ST_LOAD: begin
               pkt_data_d  = dout;
               pkt_valid_d = 1'b1;
               state_d     = ST_SEND;
            end

            ST_SEND: begin
               if (pkt_ready) begin
                  pkt_valid_d   = 1'b0;
                  timer_clear_s = 1'b1;
                  state_d       = ST_ACKWAIT;
               end else begin
                  state_d = ST_SEND;
               end
            end

            ST_ACKWAIT: begin
               timer_enable_s = 1'b1;
               // A matching ack on the expiry cycle still counts as delivered.
               if (ack_match_s) begin
                  if (last_packet_s) begin
                     done_d  = 1'b1;
                     state_d = ST_IDLE;
                  end else begin
                     readaddr_d = readaddr_q + ADDR_ONE;
                     pkt_seq_d  = pkt_seq_q + SEQ_ONE;
                     retry_d    = '0;
                     state_d    = ST_FETCH;
                  end
               end else if (timer_expired_s) begin
                  if (retry_q == RETRY_LIMIT) begin
                     state_d = ST_FAIL;
                  end else begin
                     // Resend the held payload; the BRAM is not read again.
                     retry_d     = retry_q + RETRY_ONE;
                     pkt_valid_d = 1'b1;
                     state_d     = ST_SEND;
                  end
               end else begin
                  state_d = ST_ACKWAIT;
               end
            end

            default: begin
               state_d     = ST_IDLE;
               pkt_valid_d = 1'b0;
            end
         endcase
      end

      busy_d = (state_d != ST_IDLE) && (state_d != ST_FAIL);
      fail_d = (state_d == ST_FAIL);
   end

   // State, datapath and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         readaddr_q  <= '0;
         maxaddr_q   <= '0;
         pkt_data_q  <= '0;
         pkt_seq_q   <= '0;
         pkt_valid_q <= 1'b0;
         retry_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         readaddr_q  <= readaddr_d;
         maxaddr_q   <= maxaddr_d;
         pkt_data_q  <= pkt_data_d;
         pkt_seq_q   <= pkt_seq_d;
         pkt_valid_q <= pkt_valid_d;
         retry_q     <= retry_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         fail_q      <= fail_d;
      end
   end

   assign readaddr  = readaddr_q;
   assign pkt_data  = pkt_data_q;
   assign pkt_seq   = pkt_seq_q;
   assign pkt_valid = pkt_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign fail      = fail_q;

endmodule

// File: tb/tb_message_tx_sequencer.sv
// -----------------------------------------------------------------------------
// tb_message_tx_sequencer
//   Randomized bench for message_tx_sequencer. A behavioural model walks the
//   message one packet at a time (expected word, sequence number, attempts
//   left) and states, in cycles relative to start/accept/ack, when the
//   packet, done and fail must appear. Inputs change and outputs are sampled
//   on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_message_tx_sequencer;

   localparam int LOGSIZE   = 10;
   localparam int WIDTH     = 64;
   localparam int SEQW      = 8;
   localparam int TIMEOUT   = 8;
   localparam int MAX_RETRY = 2;

   localparam int POL_ALWAYS = 0;   // every attempt acked at a random delay
   localparam int POL_LOSSY  = 1;   // acks randomly dropped
   localparam int POL_NEVER  = 2;   // no ack ever

   localparam int MODE_NONE  = 0;
   localparam int MODE_ABORT = 1;   // abort inside ACKWAIT of packet evt_idx
   localparam int MODE_RESET = 2;   // reset while packet evt_idx is in SEND

   logic               clk = 1'b0;
   logic               reset;
   logic               start;
   logic               abort;
   logic [LOGSIZE-1:0] maxaddr;
   logic [LOGSIZE-1:0] readaddr;
   logic [WIDTH-1:0]   dout;
   logic [WIDTH-1:0]   pkt_data;
   logic [SEQW-1:0]    pkt_seq;
   logic               pkt_valid;
   logic               pkt_ready;
   logic               ack_valid;
   logic [SEQW-1:0]    ack_seq;
   logic               busy;
   logic               done;
   logic               fail;

   int checks = 0;
   int errors = 0;
   int model_addr = 0;   // where the model expects readaddr to rest

   always #5 clk = ~clk;

   // BRAM model: registered read, mem[a] = 64'hA0 + a.
   always @(posedge clk) begin
      dout <= 64'hA0 + 64'(readaddr);
   end

   message_tx_sequencer #(
      .LOGSIZE   (LOGSIZE),
      .WIDTH     (WIDTH),
      .SEQW      (SEQW),
      .TIMEOUT   (TIMEOUT),
      .MAX_RETRY (MAX_RETRY)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .maxaddr   (maxaddr),
      .readaddr  (readaddr),
      .dout      (dout),
      .pkt_data  (pkt_data),
      .pkt_seq   (pkt_seq),
      .pkt_valid (pkt_valid),
      .pkt_ready (pkt_ready),
      .ack_valid (ack_valid),
      .ack_seq   (ack_seq),
      .busy      (busy),
      .done      (done),
      .fail      (fail)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_idle(input string tag, input bit exp_done, input bit exp_fail);
      check_val({tag, "_valid"}, 64'(pkt_valid), 64'd0);
      check_val({tag, "_busy"},  64'(busy),      64'd0);
      check_val({tag, "_done"},  64'(done),      64'(exp_done));
      check_val({tag, "_fail"},  64'(fail),      64'(exp_fail));
   endtask

   // Send one message of m words and follow it to done, fail, abort or reset.
   task automatic run_message(input int m, input int mode, input int evt_idx, input int policy);
      int              idx;
      int              retries;
      int              j;
      int              w;
      int              stall;
      bit              matched;
      logic [SEQW-1:0] eseq;
      logic [63:0]     edata;

      maxaddr = LOGSIZE'(m);
      start   = 1'b1;
      tick();
      start   = 1'b0;
      maxaddr = LOGSIZE'($urandom_range(0, 1023));

      if (m == 0) begin
         check_idle("zero", 1'b1, 1'b0);
         check_val("zero_addr", 64'(readaddr), 64'(model_addr));
         tick();
         check_idle("zero_after", 1'b0, 1'b0);
         check_val("zero_addr2", 64'(readaddr), 64'(model_addr));
         return;
      end

      check_val("start_fail_clr", 64'(fail), 64'd0);
      check_val("start_busy", 64'(busy), 64'd1);
      check_val("fetch_valid", 64'(pkt_valid), 64'd0);
      tick();
      check_val("load_valid", 64'(pkt_valid), 64'd0);
      tick();

      idx     = 1;
      retries = 0;
      while (idx <= m) begin
         eseq  = SEQW'((idx - 1) % 256);
         edata = 64'hA0 + 64'(idx);
         check_val("pkt_valid", 64'(pkt_valid), 64'd1);
         check_val("pkt_data",  pkt_data,       edata);
         check_val("pkt_seq",   64'(pkt_seq),   64'(eseq));
         check_val("pkt_addr",  64'(readaddr),  64'(idx));
         check_val("pkt_busy",  64'(busy),      64'd1);

         if (mode == MODE_RESET && idx == evt_idx) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            check_idle("rst", 1'b0, 1'b0);
            check_val("rst_data", pkt_data, 64'd0);
            check_val("rst_seq",  64'(pkt_seq),  64'd0);
            check_val("rst_addr", 64'(readaddr), 64'd0);
            model_addr = 0;
            return;
         end

         // Hold-off: packet must stay put; stray acks and starts are ignored.
         stall = $urandom_range(0, 3);
         repeat (stall) begin
            pkt_ready = 1'b0;
            ack_valid = 1'($urandom_range(0, 1));
            ack_seq   = eseq;
            start     = 1'($urandom_range(0, 1));
            tick();
            ack_valid = 1'b0;
            start     = 1'b0;
            check_val("hold_valid", 64'(pkt_valid), 64'd1);
            check_val("hold_data",  pkt_data,       edata);
            check_val("hold_seq",   64'(pkt_seq),   64'(eseq));
         end

         pkt_ready = 1'b1;
         tick();
         pkt_ready = 1'($urandom_range(0, 1));
         check_val("accept_valid", 64'(pkt_valid), 64'd0);

         if (mode == MODE_ABORT && idx == evt_idx) begin
            repeat ($urandom_range(0, TIMEOUT - 2)) tick();
            abort = 1'b1;
            start = 1'b1;
            tick();
            abort = 1'b0;
            start = 1'b0;
            check_idle("abort", 1'b0, 1'b0);
            model_addr = idx;
            return;
         end

         // Ack slot j (1..TIMEOUT) lands while the timer shows j-1; 0 = no ack.
         if (policy == POL_NEVER) begin
            j = 0;
         end else if (policy == POL_LOSSY && $urandom_range(0, 3) == 0) begin
            j = 0;
         end else if ($urandom_range(0, 3) == 0) begin
            j = TIMEOUT;
         end else begin
            j = $urandom_range(1, TIMEOUT);
         end
         w = ($urandom_range(0, 1) == 1) ? $urandom_range(1, TIMEOUT) : 0;

         matched = 1'b0;
         for (int n = 1; n <= TIMEOUT; n++) begin
            if (n == j) begin
               ack_valid = 1'b1;
               ack_seq   = eseq;
            end else if (n == w) begin
               ack_valid = 1'b1;
               ack_seq   = eseq ^ SEQW'($urandom_range(1, 255));
            end else begin
               ack_valid = 1'b0;
            end
            tick();
            ack_valid = 1'b0;
            if (n == j) begin
               matched = 1'b1;
               break;
            end
            if (n < TIMEOUT) begin
               check_val("wait_valid", 64'(pkt_valid), 64'd0);
               check_val("wait_done",  64'(done),      64'd0);
            end
         end

         if (matched) begin
            if (idx == m) begin
               check_idle("done", 1'b1, 1'b0);
               tick();
               check_val("done_once", 64'(done), 64'd0);
               model_addr = idx;
               return;
            end
            check_val("next_done",  64'(done),      64'd0);
            check_val("next_valid", 64'(pkt_valid), 64'd0);
            check_val("next_busy",  64'(busy),      64'd1);
            tick();
            check_val("next_valid2", 64'(pkt_valid), 64'd0);
            tick();
            idx++;
            retries = 0;
         end else begin
            if (retries == MAX_RETRY) begin
               check_idle("fail", 1'b0, 1'b1);
               model_addr = idx;
               return;
            end
            retries++;
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      maxaddr   = '0;
      pkt_ready = 1'b0;
      ack_valid = 1'b0;
      ack_seq   = '0;
      repeat (3) tick();
      check_idle("reset", 1'b0, 1'b0);
      check_val("reset_addr", 64'(readaddr), 64'd0);
      check_val("reset_data", pkt_data, 64'd0);
      check_val("reset_seq",  64'(pkt_seq), 64'd0);
      reset = 1'b0;
      tick();

      run_message(0, MODE_NONE, 0, POL_ALWAYS);
      run_message(3, MODE_NONE, 0, POL_ALWAYS);
      run_message(2, MODE_NONE, 0, POL_NEVER);
      tick();
      check_val("fail_hold", 64'(fail), 64'd1);
      check_val("fail_busy", 64'(busy), 64'd0);
      run_message(2, MODE_NONE, 0, POL_ALWAYS);
      run_message(3, MODE_ABORT, 2, POL_ALWAYS);
      run_message(1, MODE_NONE, 0, POL_ALWAYS);
      run_message(3, MODE_RESET, 2, POL_ALWAYS);
      run_message(2, MODE_NONE, 0, POL_ALWAYS);

      for (int k = 0; k < 25; k++) begin
         run_message($urandom_range(0, 6), MODE_NONE, 0,
                     ($urandom_range(0, 4) == 0) ? POL_NEVER : POL_LOSSY);
      end

      // Long message so the sequence number wraps past 255.
      run_message(260, MODE_NONE, 0, POL_ALWAYS);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: bench did not finish (checks %0d)", checks);
      $fatal(1);
   end

endmodule
